// File: rtl/ng_adr_banked.sv
// ng_adr_banked: address decode and bank register unit.
//
// Holds the S address register and the erasable (EB), fixed (FB) and superbank (SB) bank
// registers. It maps S onto an erasable or fixed physical address and runs one memory access
// per START with a REQ/ACK handshake. A missing ACK ends the access with an ERR pulse after a
// timeout. A received ACK is followed by settle wait-states and then a DONE pulse.
//
// Ports:
//   CLK2       system clock, rising edge
//   GENRST     asynchronous active-high reset
//   WRITE_BUS  write bus data
//   WS_n       load S  <= WRITE_BUS[11:0]
//   WEB_n      load EB <= WRITE_BUS[8+EB_W-1:8]
//   WFB_n      load FB <= WRITE_BUS[14:10]
//   WBB_n      load FB <= WRITE_BUS[14:10], EB <= WRITE_BUS[EB_W-1:0] (beats WEB_n/WFB_n)
//   WSB_n      load SB <= WRITE_BUS[6] (held at 0 when SB_EN = 0)
//   START_n    begin a memory access (sampled only when idle)
//   MEM_ACK    memory acknowledge (sampled only while requesting)
//   BANK_BUS   {0, FB, 7'b0, EB zero-extended to 3 bits}
//   EADDR      erasable physical address, latched at START
//   FADDR      fixed physical address {PB, S[9:0]}, latched at START
//   ERASABLE   latched access targets erasable memory
//   MEM_REQ    memory request
//   BUSY       access in progress
//   DONE       one-cycle pulse, access complete
//   ERR        one-cycle pulse, access timed out
//   SELECT     active-low S decodes: EQU_16, EQU_17, EQU_25, GTR_17, GTR_27, GTR_1777 (octal)
module ng_adr_banked #(
  parameter int unsigned EB_W        = 3,
  parameter int unsigned SB_EN       = 1,
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned TIMEOUT     = 15
) (
  input  logic            CLK2,
  input  logic            GENRST,
  input  logic [15:0]     WRITE_BUS,
  input  logic            WS_n,
  input  logic            WEB_n,
  input  logic            WFB_n,
  input  logic            WBB_n,
  input  logic            WSB_n,
  input  logic            START_n,
  input  logic            MEM_ACK,
  output logic [15:0]     BANK_BUS,
  output logic [EB_W+7:0] EADDR,
  output logic [15:0]     FADDR,
  output logic            ERASABLE,
  output logic            MEM_REQ,
  output logic            BUSY,
  output logic            DONE,
  output logic            ERR,
  output logic [5:0]      SELECT
);

  // Last counter values before leaving REQ (timeout) and WAIT (settle done).
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);
  localparam logic [7:0] WaitLast    = 8'(WAIT_STATES);

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait
  } state_e;

  // ---------------------------------------------------------------------------------------------
  // Address and bank registers
  // ---------------------------------------------------------------------------------------------
  logic [11:0]     s_q, s_d;
  logic [EB_W-1:0] eb_q, eb_d;
  logic [4:0]      fb_q, fb_d;
  logic            sb_q, sb_d;

  // WRITE_BUS[15] carries nothing for this unit.
  logic unused_write_bus;
  assign unused_write_bus = WRITE_BUS[15];

  always_comb begin
    s_d  = s_q;
    eb_d = eb_q;
    fb_d = fb_q;
    sb_d = sb_q;
    if (!WS_n) begin
      s_d = WRITE_BUS[11:0];
    end
    if (!WBB_n) begin
      // Combined BBANK write wins over the separate EB/FB strobes.
      fb_d = WRITE_BUS[14:10];
      eb_d = WRITE_BUS[EB_W-1:0];
    end else begin
      if (!WEB_n) begin
        eb_d = WRITE_BUS[EB_W+7:8];
      end
      if (!WFB_n) begin
        fb_d = WRITE_BUS[14:10];
      end
    end
    if (!WSB_n) begin
      sb_d = (SB_EN != 0) && WRITE_BUS[6];
    end
  end

  always_ff @(posedge CLK2 or posedge GENRST) begin
    if (GENRST) begin
      s_q  <= '0;
      eb_q <= '0;
      fb_q <= '0;
      sb_q <= 1'b0;
    end else begin
      s_q  <= s_d;
      eb_q <= eb_d;
      fb_q <= fb_d;
      sb_q <= sb_d;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Combinational mapping of the current registers
  // ---------------------------------------------------------------------------------------------
  logic [2:0]       eb_ext;
  logic [2:0]       ebank;
  logic [5:0]       pb;
  logic             map_erasable;
  logic [EB_W+7:0]  map_eaddr;
  logic [15:0]      map_faddr;

  always_comb begin
    eb_ext             = '0;
    eb_ext[EB_W-1:0]   = eb_q;
  end

  // S[9:8] = 11 selects the switchable erasable bank; 00..10 address banks 0..2 directly.
  assign ebank        = (s_q[9:8] == 2'b11) ? eb_ext : {1'b0, s_q[9:8]};
  assign map_erasable = (s_q[11:10] == 2'b00);
  assign map_eaddr    = map_erasable ? {ebank[EB_W-1:0], s_q[7:0]} : '0;

  always_comb begin
    pb = '0;
    unique case (s_q[11:10])
      2'b00:   pb = '0;
      // Superbank only extends FB banks 30-37 (octal), i.e. FB[4:3] = 11.
      2'b01:   pb = {sb_q & fb_q[4] & fb_q[3], fb_q};
      2'b10:   pb = 6'd2;
      2'b11:   pb = 6'd3;
      default: pb = '0;
    endcase
  end

  assign map_faddr = {pb, s_q[9:0]};

  assign BANK_BUS = {1'b0, fb_q, 7'b0, eb_ext};

  assign SELECT[0] = ~(s_q == 12'o0016);
  assign SELECT[1] = ~(s_q == 12'o0017);
  assign SELECT[2] = ~(s_q == 12'o0025);
  assign SELECT[3] = ~(s_q >  12'o0017);
  assign SELECT[4] = ~(s_q >  12'o0027);
  assign SELECT[5] = ~(s_q >  12'o1777);

  // ---------------------------------------------------------------------------------------------
  // Access sequencer
  // ---------------------------------------------------------------------------------------------
  state_e          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [7:0]      cnt_inc;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            erasable_q, erasable_d;
  logic [EB_W+7:0] eaddr_q, eaddr_d;
  logic [15:0]     faddr_q, faddr_d;

  // Saturating so a long stall can never wrap back under the limit.
  assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    erasable_d = erasable_q;
    eaddr_d    = eaddr_q;
    faddr_d    = faddr_q;
    unique case (state_q)
      StIdle: begin
        if (!START_n) begin
          // Registered values only: a same-edge S write belongs to the next access.
          erasable_d = map_erasable;
          eaddr_d    = map_eaddr;
          faddr_d    = map_faddr;
          cnt_d      = '0;
          state_d    = StReq;
        end
      end
      StReq: begin
        if (MEM_ACK) begin
          cnt_d   = '0;
          state_d = StWait;
        end else if (cnt_q >= TimeoutLast) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StWait: begin
        if (cnt_q >= WaitLast) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK2 or posedge GENRST) begin
    if (GENRST) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      erasable_q <= 1'b0;
      eaddr_q    <= '0;
      faddr_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      err_q      <= err_d;
      erasable_q <= erasable_d;
      eaddr_q    <= eaddr_d;
      faddr_q    <= faddr_d;
    end
  end

  assign MEM_REQ  = (state_q == StReq);
  assign BUSY     = (state_q != StIdle);
  assign DONE     = done_q;
  assign ERR      = err_q;
  assign ERASABLE = erasable_q;
  assign EADDR    = eaddr_q;
  assign FADDR    = faddr_q;

endmodule

// File: tb/tb_ng_adr_banked.sv
// Bench for ng_adr_banked: a table of register-write vectors checking BANK_BUS and SELECT,
// followed by hand-written access sequences (mapping, handshake, timeout, reset).
// A second instance with SB_EN = 0 shares all inputs to cover the superbank-disabled mapping.
module tb_ng_adr_banked;

  localparam logic [4:0] M_WS  = 5'b00001;
  localparam logic [4:0] M_WEB = 5'b00010;
  localparam logic [4:0] M_WFB = 5'b00100;
  localparam logic [4:0] M_WBB = 5'b01000;
  localparam logic [4:0] M_WSB = 5'b10000;

  logic        CLK2 = 1'b0;
  logic        GENRST;
  logic [15:0] WRITE_BUS;
  logic        WS_n, WEB_n, WFB_n, WBB_n, WSB_n, START_n, MEM_ACK;

  logic [15:0] bank_a, faddr_a, bank_b, faddr_b;
  logic [10:0] eaddr_a, eaddr_b;
  logic        eras_a, req_a, busy_a, done_a, err_a;
  logic        eras_b, req_b, busy_b, done_b, err_b;
  logic [5:0]  sel_a, sel_b;

  int n_chk = 0;
  int n_err = 0;

  always #5 CLK2 = ~CLK2;

  ng_adr_banked u_dut (
    .CLK2      (CLK2),
    .GENRST    (GENRST),
    .WRITE_BUS (WRITE_BUS),
    .WS_n      (WS_n),
    .WEB_n     (WEB_n),
    .WFB_n     (WFB_n),
    .WBB_n     (WBB_n),
    .WSB_n     (WSB_n),
    .START_n   (START_n),
    .MEM_ACK   (MEM_ACK),
    .BANK_BUS  (bank_a),
    .EADDR     (eaddr_a),
    .FADDR     (faddr_a),
    .ERASABLE  (eras_a),
    .MEM_REQ   (req_a),
    .BUSY      (busy_a),
    .DONE      (done_a),
    .ERR       (err_a),
    .SELECT    (sel_a)
  );

  ng_adr_banked #(
    .SB_EN (0)
  ) u_dut_nosb (
    .CLK2      (CLK2),
    .GENRST    (GENRST),
    .WRITE_BUS (WRITE_BUS),
    .WS_n      (WS_n),
    .WEB_n     (WEB_n),
    .WFB_n     (WFB_n),
    .WBB_n     (WBB_n),
    .WSB_n     (WSB_n),
    .START_n   (START_n),
    .MEM_ACK   (MEM_ACK),
    .BANK_BUS  (bank_b),
    .EADDR     (eaddr_b),
    .FADDR     (faddr_b),
    .ERASABLE  (eras_b),
    .MEM_REQ   (req_b),
    .BUSY      (busy_b),
    .DONE      (done_b),
    .ERR       (err_b),
    .SELECT    (sel_b)
  );

  typedef struct {
    string       name;
    logic [4:0]  wr;
    logic [15:0] wb;
    logic [15:0] exp_bank;
    logic [5:0]  exp_sel;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input string name, input logic [4:0] wr, input logic [15:0] wb,
                              input logic [15:0] exp_bank, input logic [5:0] exp_sel);
    vec_t v;
    v.name     = name;
    v.wr       = wr;
    v.wb       = wb;
    v.exp_bank = exp_bank;
    v.exp_sel  = exp_sel;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK2);
    #1;
  endtask

  task automatic wr(input logic [4:0] m, input logic [15:0] wb);
    WRITE_BUS = wb;
    WS_n  = ~m[0];
    WEB_n = ~m[1];
    WFB_n = ~m[2];
    WBB_n = ~m[3];
    WSB_n = ~m[4];
    tick();
    WS_n  = 1'b1;
    WEB_n = 1'b1;
    WFB_n = 1'b1;
    WBB_n = 1'b1;
    WSB_n = 1'b1;
  endtask

  task automatic start;
    START_n = 1'b0;
    tick();
    START_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int held;
    GENRST    = 1'b1;
    WRITE_BUS = '0;
    WS_n      = 1'b1;
    WEB_n     = 1'b1;
    WFB_n     = 1'b1;
    WBB_n     = 1'b1;
    WSB_n     = 1'b1;
    START_n   = 1'b1;
    MEM_ACK   = 1'b0;

    // Register-write vectors; state carries from one row to the next.
    vq.push_back(mk("wbb_load",      M_WBB,         16'o36005, 16'o36005, 6'b111111));
    vq.push_back(mk("wfb_only",      M_WFB,         16'o04000, 16'o04005, 6'b111111));
    vq.push_back(mk("web_wfb_both",  M_WEB | M_WFB, 16'h5300,  16'h5003,  6'b111111));
    vq.push_back(mk("wbb_over_web",  M_WBB | M_WEB, 16'h1201,  16'h1001,  6'b111111));
    vq.push_back(mk("sel_equ17",     M_WS,          16'o0017,  16'h1001,  6'b111101));
    vq.push_back(mk("sel_equ16",     M_WS,          16'o0016,  16'h1001,  6'b111110));
    vq.push_back(mk("sel_equ25",     M_WS,          16'o0025,  16'h1001,  6'b110011));
    vq.push_back(mk("sel_27",        M_WS,          16'o0027,  16'h1001,  6'b110111));
    vq.push_back(mk("sel_30",        M_WS,          16'o0030,  16'h1001,  6'b100111));
    vq.push_back(mk("sel_1777",      M_WS,          16'o1777,  16'h1001,  6'b100111));
    vq.push_back(mk("sel_2000",      M_WS,          16'o2000,  16'h1001,  6'b000111));
    vq.push_back(mk("sel_20",        M_WS,          16'o0020,  16'h1001,  6'b110111));
    vq.push_back(mk("wsb_no_bank",   M_WSB,         16'h0040,  16'h1001,  6'b110111));
    vq.push_back(mk("ws_upper_bits", M_WS,          16'hF00E,  16'h1001,  6'b111110));

    // Reset state, checked while reset is still held.
    #12;
    chk("rst_bank",  {bank_a, bank_b}, 32'h0);
    chk("rst_sel",   {sel_a, sel_b}, {6'b111111, 6'b111111});
    chk("rst_ctl",   {req_a, busy_a, done_a, err_a, eras_a, req_b, busy_b, done_b, err_b, eras_b},
                     10'b0);
    chk("rst_eaddr", {eaddr_a, eaddr_b}, 22'h0);
    chk("rst_faddr", {faddr_a, faddr_b}, 32'h0);
    @(negedge CLK2);
    GENRST = 1'b0;
    tick();

    foreach (vq[i]) begin
      wr(vq[i].wr, vq[i].wb);
      chk({vq[i].name, "_bank"}, bank_a, vq[i].exp_bank);
      chk({vq[i].name, "_sel"}, sel_a, vq[i].exp_sel);
    end

    // Erasable mapping through EB, then the REQ/ACK/WAIT handshake.
    wr(M_WEB, 16'h0500);
    wr(M_WS, 16'o1523);
    start();                                     // e0
    chk("eras_eb_flag",  eras_a, 1'b1);
    chk("eras_eb_addr",  eaddr_a, 11'o2523);
    chk("hs_req_e0",     {req_a, busy_a}, 2'b11);
    START_n = 1'b0;                              // ignored: already busy
    wr(M_WS, 16'o0325);                          // e1, S write during BUSY
    START_n = 1'b1;
    chk("hs_req_e1",     req_a, 1'b1);
    chk("hs_eaddr_hold", eaddr_a, 11'o2523);
    tick();                                      // e2
    chk("hs_req_e2",     req_a, 1'b1);
    MEM_ACK = 1'b1;
    tick();                                      // e3: ACK taken
    MEM_ACK = 1'b0;
    chk("hs_ack_drop",   {req_a, busy_a, done_a}, 3'b010);
    tick();                                      // e4
    chk("hs_wait1",      {busy_a, done_a}, 2'b10);
    tick();                                      // e5
    chk("hs_done",       {busy_a, done_a}, 2'b01);
    tick();                                      // e6
    chk("hs_done_pulse", {busy_a, done_a, req_a}, 3'b000);
    chk("hs_eaddr_end",  eaddr_a, 11'o2523);

    // Direct erasable bank, then let the access time out.
    start();
    chk("eras_direct",   {eras_a, eaddr_a}, {1'b1, 11'o0325});
    held = 1;
    for (int i = 1; i < 15; i++) begin
      tick();
      if (req_a !== 1'b1 || err_a !== 1'b0) held = 0;
    end
    chk("to_req_held",   held, 1);
    tick();                                      // 15th edge in REQ
    chk("to_err",        {err_a, req_a, busy_a}, 3'b100);
    chk("to_err_b",      {err_b, req_b, busy_b}, 3'b100);
    tick();
    chk("to_err_pulse",  {err_a, busy_a}, 2'b00);

    // ACK while idle must not start anything.
    MEM_ACK = 1'b1;
    tick();
    MEM_ACK = 1'b0;
    chk("ack_idle",      {req_a, busy_a, done_a}, 3'b000);

    // Fixed mapping with superbank, and the same with SB_EN = 0.
    wr(M_WFB, 16'o72000);
    wr(M_WSB, 16'h0040);
    wr(M_WS, 16'o2345);
    start();
    chk("fix_sb_flag",   eras_a, 1'b0);
    chk("fix_sb_addr",   faddr_a, {6'o75, 10'o0345});
    chk("fix_nosb_addr", faddr_b, {6'o35, 10'o0345});
    tick();
    #2 GENRST = 1'b1;                            // mid-REQ, between edges
    #1;
    chk("rst_mid_ctl",   {req_a, busy_a, done_a, err_a}, 4'b0000);
    chk("rst_mid_regs",  {bank_a, faddr_a}, 32'h0);
    @(negedge CLK2);
    GENRST = 1'b0;
    tick();

    // PB = 2 and PB = 3, with an immediate ACK.
    wr(M_WS, 16'o4001);
    start();
    chk("fix_pb2",       {eras_a, faddr_a}, {1'b0, 6'd2, 10'o0001});
    MEM_ACK = 1'b1;
    tick();
    MEM_ACK = 1'b0;
    chk("fast_ack",      {req_a, busy_a}, 2'b01);
    tick();
    chk("fast_wait",     done_a, 1'b0);
    tick();
    chk("fast_done",     done_a, 1'b1);
    wr(M_WS, 16'o6001);
    start();
    chk("fix_pb3",       faddr_a, {6'd3, 10'o0001});

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
